step_dir_generator: RTL and testbench
=====================================

Name: step_dir_generator

Overview:
Step/dir pulse generator: the transmitting end of the step/dir interface consumed by the stepper driver.
- Accepts move commands (direction, step count, step period) over a valid/ready handshake.
- Emits timed step pulses on step_out and a direction level on dir_out, honouring pulse-width and dir-setup timing.
- Maintains a signed absolute position counter.
- Sits between a host/register interface and the uio step/dir pins of a driver instance.

Parameters:
CNT_W, 16, width of step count / steps_left
PER_W, 16, width of step period in clk cycles
PULSE_W, 4, step_out high time in cycles (>=1)
DIR_SETUP, 4, cycles dir_out must be stable before the first step rising edge after a dir change (>=1)
POS_W, 32, width of position counter

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command present
cmd_ready  out  1  high only in IDLE
cmd_dir  in  1  1 = forward (+1), 0 = reverse (-1)
cmd_steps  in  CNT_W  number of step pulses
cmd_period  in  PER_W  rising-to-rising step spacing in cycles
abort  in  1  stop the move gracefully
step_out  out  1  step pulse to driver
dir_out  out  1  direction level to driver
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse when a move ends, completed or aborted
aborted  out  1  valid with done; 1 if the move ended via abort
steps_left  out  CNT_W  remaining pulses
position  out  POS_W  signed absolute step count

Behaviour:
- Reset (async on rst_n low): state IDLE, step_out=0, dir_out=0, busy=0, done=0, aborted=0, steps_left=0, position=0, all timers 0. Reset mid-pulse drops step_out immediately.
- States: IDLE, DIR_WAIT, STEP_HI, STEP_LO, FINISH.
- Accept: occurs on the edge where cmd_valid && cmd_ready.
  - Latch cmd_steps into steps_left.
  - Latch eff_period = max(cmd_period, PULSE_W+1).
  - dir_out takes cmd_dir on the same edge.
- cmd_steps==0: go to FINISH. done=1 on the next cycle, aborted=0, no pulse, position unchanged.
- Dir changed (cmd_dir != old dir_out): go to DIR_WAIT for DIR_SETUP cycles, then STEP_HI.
- Dir unchanged: go directly to STEP_HI, so step_out is high in the cycle after accept.
- Entering STEP_HI: step_out=1, position += (dir_out ? +1 : -1) with modulo 2^POS_W wrap, steps_left -= 1.
  - Stay in STEP_HI for PULSE_W cycles, then STEP_LO.
- STEP_LO: step_out=0 for eff_period-PULSE_W cycles.
  - Then STEP_HI if steps_left != 0, else FINISH.
- FINISH: single cycle. done=1, busy=0 on the following cycle, return to IDLE. cmd_ready is asserted in the cycle after done.
- abort:
  - In DIR_WAIT: go to FINISH immediately with aborted=1 and no pulse.
  - In STEP_HI: the pulse completes its full PULSE_W cycles (never truncated), then FINISH with aborted=1.
  - In STEP_LO: go to FINISH on the next edge.
  - In IDLE or FINISH: ignored.
  - steps_left retains the untaken count until the next accept.
- cmd_valid while busy is not accepted and has no effect.
- dir_out never changes while busy.
- Period counters saturate and never wrap. eff_period is computed in PER_W+1 bits.

Optional Feature:
STEPGEN_RAMP_EN: linear acceleration/deceleration.
- With the macro:
  - Parameters RAMP_START (default 16'd2000) and RAMP_DEC (default 16'd50) apply.
  - The first pulse uses cur_period = max(RAMP_START, eff_period).
  - After each pulse, cur_period decreases by RAMP_DEC, floored at eff_period; ramp_cnt counts accelerating steps.
  - When steps_left <= ramp_cnt, cur_period increases by RAMP_DEC per pulse, capped at RAMP_START.
  - abort still ends the move at the next STEP_LO; there is no decel on abort.
- Without the macro: constant eff_period and no ramp logic synthesised.

Decomposition:
- Package stepgen_pkg: state enum, state width, STEP_FWD/STEP_REV constants, clamp function for eff_period.
- One sub-module, stepgen_timer: a loadable down-counter with a zero flag, used for pulse/low/setup timing. Instantiated once and reloaded per state.
- Ramp logic stays in the top module under the macro.

Test Plan:
- Accept dir=1, steps=3, period=10 from dir_out=1 -> step_out rises in the cycle after accept; 3 pulses, each high 4 cycles, rising edges 10 cycles apart; position=3; done pulse, aborted=0.
- dir=0, steps=2, period=8 from dir_out=1 -> dir_out falls on accept; first rise 4 cycles later; position decreases by 2.
- steps=0 -> done the cycle after accept; no step_out activity; position unchanged.
- period=2 with PULSE_W=4 -> rising edges 5 cycles apart (clamped).
- abort asserted in 2nd cycle of 1st pulse of a 10-step move -> pulse stays high 4 cycles; done=1, aborted=1; steps_left=9; position=+1.
- rst_n low mid-pulse -> step_out=0 and position=0 immediately, without waiting for a clock edge; cmd_ready=1 after release.

Source files
------------

// File: rtl/stepgen_pkg.sv
// Shared definitions for the step/dir pulse generator: FSM encoding, direction
// constants and the period clamp helper.
package stepgen_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE     = 3'd0,
        ST_DIR_WAIT = 3'd1,
        ST_STEP_HI  = 3'd2,
        ST_STEP_LO  = 3'd3,
        ST_FINISH   = 3'd4
    } state_t;

    localparam logic STEP_FWD = 1'b1;
    localparam logic STEP_REV = 1'b0;

    // Larger of the requested period and the shortest legal period.
    function automatic logic [31:0] clamp_period(input logic [31:0] period,
                                                 input logic [31:0] floor_val);
        return (period < floor_val) ? floor_val : period;
    endfunction

endpackage

// File: rtl/step_dir_generator_if.sv
// Move-command handshake between the host side and the step/dir generator.
interface step_dir_generator_if #(
    parameter int CNT_W = 16,
    parameter int PER_W = 16
) ();
    logic             cmd_valid;
    logic             cmd_ready;
    logic             cmd_dir;
    logic [CNT_W-1:0] cmd_steps;
    logic [PER_W-1:0] cmd_period;

    modport master (output cmd_valid, output cmd_dir, output cmd_steps,
                    output cmd_period, input cmd_ready);
    modport slave  (input cmd_valid, input cmd_dir, input cmd_steps,
                    input cmd_period, output cmd_ready);
endinterface

// File: rtl/stepgen_timer.sv
// Loadable down-counter with a zero flag; counts down to zero and holds there.
module stepgen_timer #(
    parameter int W = 17
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);
    logic [W-1:0] cnt_r;

    // Counter: load takes priority, otherwise decrement and saturate at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= {W{1'b0}};
        end else if (load) begin
            cnt_r <= load_val;
        end else if (cnt_r != {W{1'b0}}) begin
            cnt_r <= cnt_r - W'(1);
        end
    end

    assign zero = (cnt_r == {W{1'b0}});
endmodule

// File: rtl/step_dir_generator.sv
// Step/dir pulse generator driving a stepper driver's step/dir pins.
// Optional linear ramp enabled by defining STEPGEN_RAMP_EN.
module step_dir_generator
    import stepgen_pkg::*;
#(
    parameter int CNT_W     = 16,
    parameter int PER_W     = 16,
    parameter int PULSE_W   = 4,
    parameter int DIR_SETUP = 4,
    parameter int POS_W     = 32
`ifdef STEPGEN_RAMP_EN
    ,
    parameter logic [15:0] RAMP_START = 16'd2000,
    parameter logic [15:0] RAMP_DEC   = 16'd50
`endif
) (
    input  logic                 clk,
    input  logic                 rst_n,
    step_dir_generator_if.slave  cmd,
    input  logic                 abort,
    output logic                 step_out,
    output logic                 dir_out,
    output logic                 busy,
    output logic                 done,
    output logic                 aborted,
    output logic [CNT_W-1:0]     steps_left,
    output logic [POS_W-1:0]     position
);
    localparam int TW = PER_W + 1;
    localparam logic [TW-1:0] HI_LOAD    = TW'(PULSE_W - 1);
    localparam logic [TW-1:0] SETUP_LOAD = TW'(DIR_SETUP - 1);
    localparam logic [TW-1:0] LO_OFFSET  = TW'(PULSE_W + 1);

    state_t             state_r, next_state_s;
    logic               accept_s, step_entry_s;
    logic               timer_load_s, timer_zero_s;
    logic [TW-1:0]      timer_val_s;
    logic [TW-1:0]      cmd_eff_s, eff_period_r, period_s, lo_load_s;
    logic               abort_pend_r;
    logic [CNT_W-1:0]   steps_left_r;
    logic [POS_W-1:0]   position_r;
    logic               step_out_s, dir_out_s, busy_s, done_s, aborted_s, cmd_ready_s;
    logic               step_out_r, dir_out_r, busy_r, done_r, aborted_r, cmd_ready_r;

    assign accept_s  = cmd.cmd_valid && cmd_ready_r;
    assign cmd_eff_s = TW'(clamp_period(32'(cmd.cmd_period), 32'(PULSE_W + 1)));
    assign lo_load_s = period_s - LO_OFFSET;

    stepgen_timer #(.W(TW)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (timer_load_s),
        .load_val (timer_val_s),
        .zero     (timer_zero_s)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state and timer reload decisions.
    always_comb begin
        next_state_s = state_r;
        timer_load_s = 1'b0;
        timer_val_s  = {TW{1'b0}};
        case (state_r)
            ST_IDLE: begin
                if (!accept_s) begin
                    next_state_s = ST_IDLE;
                end else if (cmd.cmd_steps == {CNT_W{1'b0}}) begin
                    next_state_s = ST_FINISH;
                end else if (cmd.cmd_dir != dir_out_r) begin
                    next_state_s = ST_DIR_WAIT;
                    timer_load_s = 1'b1;
                    timer_val_s  = SETUP_LOAD;
                end else begin
                    next_state_s = ST_STEP_HI;
                    timer_load_s = 1'b1;
                    timer_val_s  = HI_LOAD;
                end
            end
            ST_DIR_WAIT: begin
                if (abort) begin
                    next_state_s = ST_FINISH;
                end else if (timer_zero_s) begin
                    next_state_s = ST_STEP_HI;
                    timer_load_s = 1'b1;
                    timer_val_s  = HI_LOAD;
                end else begin
                    next_state_s = ST_DIR_WAIT;
                end
            end
            ST_STEP_HI: begin
                // A pulse is never truncated; a pending abort is honoured at its end.
                if (!timer_zero_s) begin
                    next_state_s = ST_STEP_HI;
                end else if (abort || abort_pend_r) begin
                    next_state_s = ST_FINISH;
                end else begin
                    next_state_s = ST_STEP_LO;
                    timer_load_s = 1'b1;
                    timer_val_s  = lo_load_s;
                end
            end
            ST_STEP_LO: begin
                if (abort) begin
                    next_state_s = ST_FINISH;
                end else if (!timer_zero_s) begin
                    next_state_s = ST_STEP_LO;
                end else if (steps_left_r != {CNT_W{1'b0}}) begin
                    next_state_s = ST_STEP_HI;
                    timer_load_s = 1'b1;
                    timer_val_s  = HI_LOAD;
                end else begin
                    next_state_s = ST_FINISH;
                end
            end
            ST_FINISH: begin
                next_state_s = ST_IDLE;
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // Output decode from the upcoming state so every output leaves a flop.
    always_comb begin
        step_out_s   = (next_state_s == ST_STEP_HI);
        step_entry_s = step_out_s && (state_r != ST_STEP_HI);
        busy_s       = (next_state_s != ST_IDLE);
        done_s       = (next_state_s == ST_FINISH);
        cmd_ready_s  = (next_state_s == ST_IDLE);
        aborted_s    = done_s && (state_r != ST_IDLE) && (abort || abort_pend_r);
        dir_out_s    = accept_s ? cmd.cmd_dir : dir_out_r;
    end

    // Output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step_out_r  <= 1'b0;
            dir_out_r   <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            aborted_r   <= 1'b0;
            cmd_ready_r <= 1'b1;
        end else begin
            step_out_r  <= step_out_s;
            dir_out_r   <= dir_out_s;
            busy_r      <= busy_s;
            done_r      <= done_s;
            aborted_r   <= aborted_s;
            cmd_ready_r <= cmd_ready_s;
        end
    end

    // Move bookkeeping: remaining steps, latched period, position and abort latch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            steps_left_r <= {CNT_W{1'b0}};
            eff_period_r <= {TW{1'b0}};
            position_r   <= {POS_W{1'b0}};
            abort_pend_r <= 1'b0;
        end else begin
            if (accept_s) begin
                steps_left_r <= step_entry_s ? (cmd.cmd_steps - CNT_W'(1)) : cmd.cmd_steps;
                eff_period_r <= cmd_eff_s;
            end else if (step_entry_s) begin
                steps_left_r <= steps_left_r - CNT_W'(1);
            end
            if (step_entry_s) begin
                position_r <= (dir_out_s == STEP_REV) ? (position_r - POS_W'(1))
                                                       : (position_r + POS_W'(1));
            end
            if (state_r == ST_IDLE) begin
                abort_pend_r <= 1'b0;
            end else if ((state_r == ST_STEP_HI) && abort) begin
                abort_pend_r <= 1'b1;
            end
        end
    end

`ifdef STEPGEN_RAMP_EN
    localparam logic [TW-1:0] RAMP_DEC_T = TW'(RAMP_DEC);
    logic [TW-1:0]    cur_period_r, ramp_top_r, cmd_top_s;
    logic [TW:0]      ramp_up_s;
    logic [CNT_W-1:0] ramp_cnt_r;

    assign cmd_top_s = TW'(clamp_period(32'(RAMP_START), 32'(cmd_eff_s)));
    assign ramp_up_s = {1'b0, cur_period_r} + {1'b0, RAMP_DEC_T};

    // Ramp: start slow, speed up toward eff_period, mirror the ramp near the end.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_period_r <= {TW{1'b0}};
            ramp_top_r   <= {TW{1'b0}};
            ramp_cnt_r   <= {CNT_W{1'b0}};
        end else if (accept_s) begin
            cur_period_r <= cmd_top_s;
            ramp_top_r   <= cmd_top_s;
            ramp_cnt_r   <= {CNT_W{1'b0}};
        end else if ((state_r == ST_STEP_LO) && (next_state_s == ST_STEP_HI)) begin
            if (steps_left_r <= ramp_cnt_r) begin
                cur_period_r <= (ramp_up_s > {1'b0, ramp_top_r}) ? ramp_top_r : ramp_up_s[TW-1:0];
            end else if (cur_period_r > eff_period_r) begin
                cur_period_r <= ((cur_period_r - eff_period_r) > RAMP_DEC_T)
                                ? (cur_period_r - RAMP_DEC_T) : eff_period_r;
                ramp_cnt_r   <= ramp_cnt_r + CNT_W'(1);
            end
        end
    end

    assign period_s = cur_period_r;
`else
    assign period_s = eff_period_r;
`endif

    assign cmd.cmd_ready = cmd_ready_r;
    assign step_out      = step_out_r;
    assign dir_out       = dir_out_r;
    assign busy          = busy_r;
    assign done          = done_r;
    assign aborted       = aborted_r;
    assign steps_left    = steps_left_r;
    assign position      = position_r;
endmodule

// File: tb/tb_step_dir_generator.sv
// Scoreboard bench for step_dir_generator: a timeline model predicts each move,
// a monitor checks pulses, position and completion status when done fires.
module tb_step_dir_generator;
    localparam int CNT_W = 16, PER_W = 16, PULSE_W = 4, DIR_SETUP = 4, POS_W = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic abort = 1'b0;
    logic step_out, dir_out, busy, done, aborted;
    logic [CNT_W-1:0] steps_left;
    logic [POS_W-1:0] position;

    step_dir_generator_if #(.CNT_W(CNT_W), .PER_W(PER_W)) cmd_if ();

    step_dir_generator #(.CNT_W(CNT_W), .PER_W(PER_W), .PULSE_W(PULSE_W),
                         .DIR_SETUP(DIR_SETUP), .POS_W(POS_W)) dut (
        .clk(clk), .rst_n(rst_n), .cmd(cmd_if), .abort(abort),
        .step_out(step_out), .dir_out(dir_out), .busy(busy), .done(done),
        .aborted(aborted), .steps_left(steps_left), .position(position)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int               done_cyc;
        int               n_pulses;
        int               first_rise;
        int               eff;
        logic [POS_W-1:0] pos;
        logic [CNT_W-1:0] left;
        logic             abrt;
        logic             dir;
    } exp_t;

    exp_t sb[$];
    int tests = 0;
    int fails = 0;
    logic [POS_W-1:0] m_pos = '0;
    logic             m_dir = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Timeline model: rises at start + i*eff, abort resolved by where it lands.
    task automatic predict(input int a, input logic dir, input int steps, input int period,
                           input int ab, output exp_t e);
        int start, eff, nd, i, off;
        eff   = (period < PULSE_W + 1) ? PULSE_W + 1 : period;
        start = (dir != m_dir) ? a + DIR_SETUP : a;
        e.first_rise = start;
        e.eff  = eff;
        e.dir  = dir;
        e.abrt = 1'b0;
        if (steps == 0) begin
            e.n_pulses = 0;
            e.done_cyc = a;
        end else begin
            nd = start + steps * eff;
            e.n_pulses = steps;
            e.done_cyc = nd;
            if (ab >= a && ab < nd) begin
                e.abrt = 1'b1;
                if (ab < start) begin
                    e.n_pulses = 0;
                    e.done_cyc = ab + 1;
                end else begin
                    i = (ab - start) / eff;
                    off = (ab - start) % eff;
                    e.n_pulses = i + 1;
                    e.done_cyc = (off < PULSE_W) ? start + i * eff + PULSE_W : ab + 1;
                end
            end
        end
        e.left = CNT_W'(steps - e.n_pulses);
        m_pos  = dir ? m_pos + POS_W'(e.n_pulses) : m_pos - POS_W'(e.n_pulses);
        e.pos  = m_pos;
        m_dir  = dir;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!cmd_if.cmd_ready && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_if.cmd_ready) check("ready_timeout", 64'(cmd_if.cmd_ready), 64'd1);
    endtask

    task automatic run_move(input logic dir, input int steps, input int period,
                            input int ab_off, input bit junk);
        exp_t e;
        int a, ab, n;
        wait_ready();
        a  = cyc + 1;
        ab = (ab_off < 0) ? -1 : a + ab_off;
        predict(a, dir, steps, period, ab, e);
        sb.push_back(e);
        cmd_if.cmd_valid  = 1'b1;
        cmd_if.cmd_dir    = dir;
        cmd_if.cmd_steps  = CNT_W'(steps);
        cmd_if.cmd_period = PER_W'(period);
        @(negedge clk);
        cmd_if.cmd_valid = 1'b0;
        n = 0;
        while (!cmd_if.cmd_ready && n < 3000) begin
            abort = (cyc == ab);
            if (junk) begin
                cmd_if.cmd_valid  = 1'($urandom_range(0, 1));
                cmd_if.cmd_dir    = 1'($urandom_range(0, 1));
                cmd_if.cmd_steps  = CNT_W'($urandom_range(0, 9));
                cmd_if.cmd_period = PER_W'($urandom_range(0, 20));
            end
            @(negedge clk);
            n++;
        end
        abort = 1'b0;
        cmd_if.cmd_valid = 1'b0;
        if (!cmd_if.cmd_ready) check("move_timeout", 64'(cmd_if.cmd_ready), 64'd1);
    endtask

    // Monitor: record pulse edges, score the move when done is presented.
    int   rises[$];
    int   widths[$];
    logic prev_step = 1'b0;
    int   hi_len = 0;
    bit   chk_after = 1'b0;
    exp_t mon_e;
    always @(negedge clk) begin
        if (!rst_n) begin
            rises.delete();
            widths.delete();
            prev_step = 1'b0;
            hi_len = 0;
            chk_after = 1'b0;
        end else begin
            if (chk_after) begin
                check("ready_after_done", 64'(cmd_if.cmd_ready), 64'd1);
                check("busy_after_done", 64'(busy), 64'd0);
                check("done_single_cycle", 64'(done), 64'd0);
                chk_after = 1'b0;
            end
            if (step_out) begin
                if (!prev_step) begin
                    rises.push_back(cyc);
                    hi_len = 0;
                end
                hi_len++;
            end else if (prev_step) begin
                widths.push_back(hi_len);
            end
            prev_step = step_out;
            if (done) begin
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_done: got done=1 expected no pending move (cycle %0d)", cyc);
                end else begin
                    mon_e = sb.pop_front();
                    check("done_cycle", 64'(cyc), 64'(mon_e.done_cyc));
                    check("pulse_count", 64'(rises.size()), 64'(mon_e.n_pulses));
                    check("width_count", 64'(widths.size()), 64'(mon_e.n_pulses));
                    for (int i = 0; i < rises.size(); i++)
                        if (i < mon_e.n_pulses)
                            check("rise_cycle", 64'(rises[i]), 64'(mon_e.first_rise + i * mon_e.eff));
                    for (int i = 0; i < widths.size(); i++)
                        check("pulse_width", 64'(widths[i]), 64'(PULSE_W));
                    check("position", 64'(position), 64'(mon_e.pos));
                    check("steps_left", 64'(steps_left), 64'(mon_e.left));
                    check("aborted", 64'(aborted), 64'(mon_e.abrt));
                    check("dir_out", 64'(dir_out), 64'(mon_e.dir));
                    check("busy_in_finish", 64'(busy), 64'd1);
                    rises.delete();
                    widths.delete();
                    chk_after = 1'b1;
                end
            end
        end
    end

    initial begin
        cmd_if.cmd_valid  = 1'b0;
        cmd_if.cmd_dir    = 1'b0;
        cmd_if.cmd_steps  = '0;
        cmd_if.cmd_period = '0;
        repeat (3) @(negedge clk);
        check("rst_step_out", 64'(step_out), 64'd0);
        check("rst_dir_out", 64'(dir_out), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_aborted", 64'(aborted), 64'd0);
        check("rst_steps_left", 64'(steps_left), 64'd0);
        check("rst_position", 64'(position), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_cmd_ready", 64'(cmd_if.cmd_ready), 64'd1);

        run_move(1'b1, 0, 7, -1, 1'b0);   // zero steps, also sets dir_out=1
        run_move(1'b1, 3, 10, -1, 1'b0);
        run_move(1'b0, 2, 8, -1, 1'b0);   // dir change -> setup wait
        run_move(1'b0, 0, 3, -1, 1'b0);
        run_move(1'b1, 3, 2, -1, 1'b0);   // clamped period
        run_move(1'b1, 3, 2, -1, 1'b1);
        run_move(1'b1, 10, 10, 1, 1'b0);  // abort in 2nd cycle of 1st pulse
        run_move(1'b0, 5, 6, 2, 1'b0);    // abort during dir setup
        run_move(1'b0, 4, 9, 6, 1'b0);    // abort in low phase
        for (int k = 0; k < 40; k++) begin
            run_move(1'($urandom_range(0, 1)), int'($urandom_range(0, 6)),
                     int'($urandom_range(0, 14)),
                     ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 40)) : -1,
                     1'($urandom_range(0, 1)));
        end
        wait_ready();
        @(negedge clk);
        check("scoreboard_drained", 64'(sb.size()), 64'd0);

        // Reset in the middle of a pulse.
        cmd_if.cmd_valid  = 1'b1;
        cmd_if.cmd_dir    = m_dir;
        cmd_if.cmd_steps  = 16'd3;
        cmd_if.cmd_period = 16'd10;
        @(negedge clk);
        cmd_if.cmd_valid = 1'b0;
        check("pulse_before_reset", 64'(step_out), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_step_out", 64'(step_out), 64'd0);
        check("async_rst_position", 64'(position), 64'd0);
        check("async_rst_busy", 64'(busy), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_cmd_ready", 64'(cmd_if.cmd_ready), 64'd1);
        check("post_rst_dir_out", 64'(dir_out), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
